// File: rtl/l1tlb_missq.sv
// Miss queue between the L1 TLBs and the L2 TLB: merges duplicate VPN misses,
// issues one tagged L2 request per unique VPN and returns completed translations as fills.
module l1tlb_missq #(
  parameter int unsigned Entries = 4,
  parameter int unsigned VpnBits = 20,
  parameter int unsigned PpnBits = 20,
  parameter int unsigned TidBits = $clog2(Entries)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_valid,
  output logic               miss_retry,
  input  logic [VpnBits-1:0] miss_vpn,
  input  logic               miss_prefetch,
  output logic               l1tlbtol2tlb_req_valid,
  input  logic               l1tlbtol2tlb_req_retry,
  output logic [VpnBits-1:0] l1tlbtol2tlb_req_vpn,
  output logic [TidBits-1:0] l1tlbtol2tlb_req_tid,
  input  logic               l2tlbtol1tlb_ack_valid,
  output logic               l2tlbtol1tlb_ack_retry,
  input  logic [TidBits-1:0] l2tlbtol1tlb_ack_tid,
  input  logic [PpnBits-1:0] l2tlbtol1tlb_ack_ppn,
  input  logic               l2tlbtol1tlb_ack_fault,
  output logic               fill_valid,
  input  logic               fill_retry,
  output logic [VpnBits-1:0] fill_vpn,
  output logic [PpnBits-1:0] fill_ppn,
  output logic               fill_fault,
  output logic               fill_prefetch,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {FREE, PEND, WAIT, FILL} ent_state_e;

  ent_state_e         state_q [Entries];
  ent_state_e         state_d [Entries];
  logic [VpnBits-1:0] vpn_q   [Entries];
  logic [PpnBits-1:0] ppn_q   [Entries];
  logic [Entries-1:0] fault_q, pf_q;
  logic               req_lock_q, fill_lock_q, err_q;
  logic [TidBits-1:0] req_idx_q, fill_idx_q;

  logic               pend_any, fst_any, free_any;
  logic [TidBits-1:0] pend_sel, fst_sel, free_sel;
  logic [TidBits-1:0] req_tid, fill_tid;
  logic               req_fire, fill_fire, ack_hit, match, miss_fire, alloc;
  logic [Entries-1:0] match_vec;

  // Outputs and lowest-index selections depend on registered state only.
  always_comb begin
    pend_any = 1'b0;
    fst_any  = 1'b0;
    free_any = 1'b0;
    pend_sel = '0;
    fst_sel  = '0;
    free_sel = '0;
    busy     = 1'b0;
    for (int unsigned i = Entries; i > 0; i--) begin
      if (state_q[i-1] == PEND) begin
        pend_any = 1'b1;
        pend_sel = TidBits'(i-1);
      end
      if (state_q[i-1] == FILL) begin
        fst_any = 1'b1;
        fst_sel = TidBits'(i-1);
      end
      if (state_q[i-1] == FREE) begin
        free_any = 1'b1;
        free_sel = TidBits'(i-1);
      end else begin
        busy = 1'b1;
      end
    end
    req_tid                = req_lock_q ? req_idx_q : pend_sel;
    fill_tid               = fill_lock_q ? fill_idx_q : fst_sel;
    l1tlbtol2tlb_req_valid = req_lock_q | pend_any;
    l1tlbtol2tlb_req_tid   = req_tid;
    l1tlbtol2tlb_req_vpn   = vpn_q[req_tid];
    fill_valid             = fill_lock_q | fst_any;
    fill_vpn               = vpn_q[fill_tid];
    fill_ppn               = ppn_q[fill_tid];
    fill_fault             = fault_q[fill_tid];
    fill_prefetch          = pf_q[fill_tid];
    l2tlbtol1tlb_ack_retry = 1'b0;
    err                    = err_q;
  end

  // Per-entry next state; the four events always touch distinct entries.
  always_comb begin
    req_fire  = l1tlbtol2tlb_req_valid & ~l1tlbtol2tlb_req_retry;
    fill_fire = fill_valid & ~fill_retry;
    match_vec = '0;
    for (int unsigned i = 0; i < Entries; i++) begin
      match_vec[i] = (state_q[i] != FREE) && (vpn_q[i] == miss_vpn) &&
                     !(fill_fire && (fill_tid == TidBits'(i)));
    end
    match      = |match_vec;
    miss_retry = reset | (~match & ~free_any);
    miss_fire  = miss_valid & ~miss_retry;
    alloc      = miss_fire & ~match;
    ack_hit    = l2tlbtol1tlb_ack_valid && (state_q[l2tlbtol1tlb_ack_tid] == WAIT);
    for (int unsigned i = 0; i < Entries; i++) state_d[i] = state_q[i];
    if (alloc)     state_d[free_sel]             = PEND;
    if (req_fire)  state_d[req_tid]              = WAIT;
    if (ack_hit)   state_d[l2tlbtol1tlb_ack_tid] = FILL;
    if (fill_fire) state_d[fill_tid]             = FREE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < Entries; i++) state_q[i] <= FREE;
      req_lock_q  <= 1'b0;
      fill_lock_q <= 1'b0;
      req_idx_q   <= '0;
      fill_idx_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < Entries; i++) state_q[i] <= state_d[i];
      // A stalled selection stays locked so the payload holds until transfer.
      if (req_fire) req_lock_q <= 1'b0;
      else if (l1tlbtol2tlb_req_valid) begin
        req_lock_q <= 1'b1;
        req_idx_q  <= req_tid;
      end
      if (fill_fire) fill_lock_q <= 1'b0;
      else if (fill_valid) begin
        fill_lock_q <= 1'b1;
        fill_idx_q  <= fill_tid;
      end
      if (l2tlbtol1tlb_ack_valid && !ack_hit) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      vpn_q[free_sel] <= miss_vpn;
      pf_q[free_sel]  <= miss_prefetch;
    end else if (miss_fire && !miss_prefetch) begin
      pf_q <= pf_q & ~match_vec;
    end
    if (ack_hit) begin
      ppn_q[l2tlbtol1tlb_ack_tid]   <= l2tlbtol1tlb_ack_ppn;
      fault_q[l2tlbtol1tlb_ack_tid] <= l2tlbtol1tlb_ack_fault;
    end
  end

endmodule

// File: tb/tb_l1tlb_missq.sv
// Directed bench for l1tlb_missq: merge, issue, ack, fill, lock, full-queue and error cases.
module tb_l1tlb_missq;
  localparam int unsigned Entries = 4;
  localparam int unsigned VpnBits = 20;
  localparam int unsigned PpnBits = 20;
  localparam int unsigned TidBits = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               miss_valid = 1'b0;
  logic               miss_retry;
  logic [VpnBits-1:0] miss_vpn = '0;
  logic               miss_prefetch = 1'b0;
  logic               req_valid;
  logic               req_retry = 1'b0;
  logic [VpnBits-1:0] req_vpn;
  logic [TidBits-1:0] req_tid;
  logic               ack_valid = 1'b0;
  logic               ack_retry;
  logic [TidBits-1:0] ack_tid = '0;
  logic [PpnBits-1:0] ack_ppn = '0;
  logic               ack_fault = 1'b0;
  logic               fill_valid;
  logic               fill_retry = 1'b0;
  logic [VpnBits-1:0] fill_vpn;
  logic [PpnBits-1:0] fill_ppn;
  logic               fill_fault;
  logic               fill_prefetch;
  logic               busy;
  logic               err;

  always #5 clk = ~clk;

  l1tlb_missq #(.Entries(Entries), .VpnBits(VpnBits), .PpnBits(PpnBits)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .miss_valid             (miss_valid),
    .miss_retry             (miss_retry),
    .miss_vpn               (miss_vpn),
    .miss_prefetch          (miss_prefetch),
    .l1tlbtol2tlb_req_valid (req_valid),
    .l1tlbtol2tlb_req_retry (req_retry),
    .l1tlbtol2tlb_req_vpn   (req_vpn),
    .l1tlbtol2tlb_req_tid   (req_tid),
    .l2tlbtol1tlb_ack_valid (ack_valid),
    .l2tlbtol1tlb_ack_retry (ack_retry),
    .l2tlbtol1tlb_ack_tid   (ack_tid),
    .l2tlbtol1tlb_ack_ppn   (ack_ppn),
    .l2tlbtol1tlb_ack_fault (ack_fault),
    .fill_valid             (fill_valid),
    .fill_retry             (fill_retry),
    .fill_vpn               (fill_vpn),
    .fill_ppn               (fill_ppn),
    .fill_fault             (fill_fault),
    .fill_prefetch          (fill_prefetch),
    .busy                   (busy),
    .err                    (err)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic [VpnBits-1:0] v, input logic pf);
    miss_valid    = 1'b1;
    miss_vpn      = v;
    miss_prefetch = pf;
  endtask

  task automatic ack(input logic [TidBits-1:0] t, input logic [PpnBits-1:0] p, input logic f);
    ack_valid = 1'b1;
    ack_tid   = t;
    ack_ppn   = p;
    ack_fault = f;
  endtask

  initial begin
    // Reset state
    cyc();
    cyc();
    chk("rst_req_valid", 32'(req_valid), 32'h0);
    chk("rst_fill_valid", 32'(fill_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_miss_retry", 32'(miss_retry), 32'h1);
    chk("rst_ack_retry", 32'(ack_retry), 32'h0);
    reset = 1'b0;

    // Basic miss -> request -> ack -> fill
    miss(20'h12345, 1'b0);
    #1;
    chk("t1_miss_accept", 32'(miss_retry), 32'h0);
    chk("t1_req_not_yet", 32'(req_valid), 32'h0);
    cyc();
    miss_valid = 1'b0;
    chk("t1_req_valid", 32'(req_valid), 32'h1);
    chk("t1_req_vpn", 32'(req_vpn), 32'h12345);
    chk("t1_req_tid", 32'(req_tid), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    cyc();
    chk("t1_req_done", 32'(req_valid), 32'h0);
    ack(2'd0, 20'hABCDE, 1'b0);
    cyc();
    ack_valid = 1'b0;
    chk("t1_fill_valid", 32'(fill_valid), 32'h1);
    chk("t1_fill_vpn", 32'(fill_vpn), 32'h12345);
    chk("t1_fill_ppn", 32'(fill_ppn), 32'hABCDE);
    chk("t1_fill_fault", 32'(fill_fault), 32'h0);
    cyc();
    chk("t1_fill_done", 32'(fill_valid), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // Merge while WAIT clears prefetch, single request
    miss(20'h00100, 1'b1);
    cyc();
    miss_valid = 1'b0;
    chk("t2_req_vpn", 32'(req_vpn), 32'h00100);
    cyc();
    chk("t2_req_done", 32'(req_valid), 32'h0);
    miss(20'h00100, 1'b0);
    #1;
    chk("t2_dup_accept", 32'(miss_retry), 32'h0);
    cyc();
    miss_valid = 1'b0;
    chk("t2_no_second_req", 32'(req_valid), 32'h0);
    ack(2'd0, 20'h55555, 1'b0);
    cyc();
    ack_valid = 1'b0;
    chk("t2_fill_vpn", 32'(fill_vpn), 32'h00100);
    chk("t2_fill_prefetch", 32'(fill_prefetch), 32'h0);
    cyc();
    chk("t2_idle_busy", 32'(busy), 32'h0);

    // Full queue
    miss(20'h00001, 1'b0); cyc();
    miss(20'h00002, 1'b0); cyc();
    miss(20'h00003, 1'b0); cyc();
    miss(20'h00004, 1'b0); cyc();
    miss_valid = 1'b0;
    cyc();
    chk("t3_full_no_req", 32'(req_valid), 32'h0);
    miss(20'h00005, 1'b0);
    #1;
    chk("t3_new_retried", 32'(miss_retry), 32'h1);
    miss(20'h00003, 1'b0);
    #1;
    chk("t3_dup_accepted", 32'(miss_retry), 32'h0);
    cyc();
    miss(20'h00005, 1'b0);
    ack(2'd0, 20'h11111, 1'b0);
    #1;
    chk("t3_ack_cycle_retry", 32'(miss_retry), 32'h1);
    cyc();
    ack_valid = 1'b0;
    #1;
    chk("t3_fill_vpn", 32'(fill_vpn), 32'h00001);
    chk("t3_fill_ppn", 32'(fill_ppn), 32'h11111);
    chk("t3_free_same_cycle", 32'(miss_retry), 32'h1);
    cyc();
    chk("t3_free_next_cycle", 32'(miss_retry), 32'h0);
    cyc();
    miss_valid = 1'b0;
    chk("t3_req_valid", 32'(req_valid), 32'h1);
    chk("t3_req_tid", 32'(req_tid), 32'h0);
    chk("t3_req_vpn", 32'(req_vpn), 32'h00005);
    cyc();
    ack(2'd0, 20'h00000, 1'b0); cyc();
    ack(2'd1, 20'h00000, 1'b0); cyc();
    ack(2'd2, 20'h00000, 1'b0); cyc();
    ack(2'd3, 20'h00000, 1'b0); cyc();
    ack_valid = 1'b0;
    cyc();
    cyc();
    chk("t3_drain_busy", 32'(busy), 32'h0);
    chk("t3_drain_err", 32'(err), 32'h0);

    // Request lock under req_retry
    miss(20'h0000A, 1'b0); cyc();
    miss(20'h0000B, 1'b0); cyc();
    miss_valid = 1'b0;
    cyc();
    req_retry = 1'b1;
    miss(20'h0000C, 1'b0); cyc();
    miss_valid = 1'b0;
    ack(2'd0, 20'h0000A, 1'b0);
    chk("t4_r1_valid", 32'(req_valid), 32'h1);
    chk("t4_r1_tid", 32'(req_tid), 32'h2);
    chk("t4_r1_vpn", 32'(req_vpn), 32'h0000C);
    cyc();
    ack_valid = 1'b0;
    chk("t4_fill_vpn", 32'(fill_vpn), 32'h0000A);
    chk("t4_fill_ppn", 32'(fill_ppn), 32'h0000A);
    chk("t4_r2_tid", 32'(req_tid), 32'h2);
    cyc();
    miss(20'h0000D, 1'b0);
    chk("t4_r3_tid", 32'(req_tid), 32'h2);
    cyc();
    miss_valid = 1'b0;
    chk("t4_r4_tid", 32'(req_tid), 32'h2);
    chk("t4_r4_vpn", 32'(req_vpn), 32'h0000C);
    cyc();
    chk("t4_r5_tid", 32'(req_tid), 32'h2);
    req_retry = 1'b0;
    cyc();
    chk("t4_next_valid", 32'(req_valid), 32'h1);
    chk("t4_next_tid", 32'(req_tid), 32'h0);
    chk("t4_next_vpn", 32'(req_vpn), 32'h0000D);
    cyc();
    ack(2'd0, 20'h00000, 1'b0); cyc();
    ack(2'd1, 20'h00000, 1'b0); cyc();
    ack(2'd2, 20'h00000, 1'b0); cyc();
    ack_valid = 1'b0;
    cyc();
    cyc();
    chk("t4_drain_busy", 32'(busy), 32'h0);

    // Out-of-order acks with fill stall
    miss(20'h00020, 1'b0); cyc();
    miss(20'h00021, 1'b1); cyc();
    miss_valid = 1'b0;
    cyc();
    fill_retry = 1'b1;
    ack(2'd1, 20'h22222, 1'b1); cyc();
    ack(2'd0, 20'h33333, 1'b0);
    chk("t5_f1_valid", 32'(fill_valid), 32'h1);
    chk("t5_f1_vpn", 32'(fill_vpn), 32'h00021);
    chk("t5_f1_ppn", 32'(fill_ppn), 32'h22222);
    chk("t5_f1_fault", 32'(fill_fault), 32'h1);
    chk("t5_f1_prefetch", 32'(fill_prefetch), 32'h1);
    cyc();
    ack_valid = 1'b0;
    chk("t5_f2_vpn", 32'(fill_vpn), 32'h00021);
    chk("t5_f2_ppn", 32'(fill_ppn), 32'h22222);
    cyc();
    chk("t5_f3_vpn", 32'(fill_vpn), 32'h00021);
    chk("t5_f3_fault", 32'(fill_fault), 32'h1);
    fill_retry = 1'b0;
    cyc();
    chk("t5_second_vpn", 32'(fill_vpn), 32'h00020);
    chk("t5_second_ppn", 32'(fill_ppn), 32'h33333);
    chk("t5_second_fault", 32'(fill_fault), 32'h0);
    chk("t5_second_prefetch", 32'(fill_prefetch), 32'h0);
    cyc();
    chk("t5_done_fill", 32'(fill_valid), 32'h0);
    chk("t5_done_busy", 32'(busy), 32'h0);

    // Ack to FREE entry sets sticky err
    chk("t6_err_before", 32'(err), 32'h0);
    ack(2'd3, 20'h44444, 1'b0); cyc();
    ack_valid = 1'b0;
    chk("t6_err_set", 32'(err), 32'h1);
    chk("t6_no_fill", 32'(fill_valid), 32'h0);
    cyc();
    cyc();
    chk("t6_err_sticky", 32'(err), 32'h1);
    chk("t6_still_no_fill", 32'(fill_valid), 32'h0);
    reset = 1'b1; cyc();
    reset = 1'b0;
    chk("t6_err_cleared", 32'(err), 32'h0);

    // Reset mid-transaction discards entries; late ack flags err
    miss(20'h00040, 1'b0); cyc();
    miss_valid = 1'b0;
    cyc();
    chk("t7_busy_before", 32'(busy), 32'h1);
    reset = 1'b1; cyc();
    reset = 1'b0;
    chk("t7_busy_after_rst", 32'(busy), 32'h0);
    chk("t7_req_after_rst", 32'(req_valid), 32'h0);
    ack(2'd0, 20'h77777, 1'b0); cyc();
    ack_valid = 1'b0;
    chk("t7_late_ack_err", 32'(err), 32'h1);
    chk("t7_late_ack_nofill", 32'(fill_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/l1tlb_missq.md
# l1tlb_missq

Miss queue between the L1 TLBs (ictlb/dctlb) and the L2 TLB. It accepts translation misses from the L1 TLB lookup stage and merges duplicate VPNs. It issues one L2 TLB request per unique VPN over the `l1tlbtol2tlb_req` port and matches tagged acks from `l2tlbtol1tlb_ack`. Completed translations return to the L1 TLB as fill transactions.

## Interface
- `Entries`, 4, number of outstanding miss entries (power of 2, ≥2)
- `VpnBits`, 20, virtual page number width
- `PpnBits`, 20, physical page number width
- `TidBits`, log2(Entries), transaction id width (derived)

- `clk`  in  1  clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `miss_valid`  in  1  L1 TLB miss present
- `miss_retry`  out  1  miss not accepted this cycle
- `miss_vpn`  in  VpnBits  missing VPN
- `miss_prefetch`  in  1  miss originated from prefetch
- `l1tlbtol2tlb_req_valid`  out  1  request to L2 TLB
- `l1tlbtol2tlb_req_retry`  in  1  L2 TLB stall
- `l1tlbtol2tlb_req_vpn`  out  VpnBits  requested VPN
- `l1tlbtol2tlb_req_tid`  out  TidBits  entry index used as tag
- `l2tlbtol1tlb_ack_valid`  in  1  translation returned
- `l2tlbtol1tlb_ack_retry`  out  1  tied 0 (acks always accepted)
- `l2tlbtol1tlb_ack_tid`  in  TidBits  tag of returned request
- `l2tlbtol1tlb_ack_ppn`  in  PpnBits  translated PPN
- `l2tlbtol1tlb_ack_fault`  in  1  translation fault
- `fill_valid`  out  1  fill to L1 TLB
- `fill_retry`  in  1  L1 TLB cannot take fill
- `fill_vpn`, `fill_ppn`, `fill_fault`, `fill_prefetch`  out  VpnBits/PpnBits/1/1  fill payload
- `busy`  out  1  any entry not FREE
- `err`  out  1  sticky: ack received for an entry not in WAIT

## Operation
- A transfer occurs on any port when `valid & ~retry`. While `retry` is high, the sender holds `valid` and its payload stable.
- Each entry holds state, vpn, ppn, fault and prefetch. Entry states are FREE, PEND, WAIT and FILL.
- **Match:** `miss_vpn` equals the vpn of a non-FREE entry. An entry whose fill transfers this cycle is excluded from the match.
- **Miss handling:**
  - On a match, the miss is accepted and merged; no new entry is created.
  - If the miss has `miss_prefetch=0`, the matched entry's prefetch bit is cleared.
  - With no match, the lowest-index FREE entry is allocated into PEND with vpn and prefetch stored.
  - `miss_retry = reset | (~match & no FREE entry)`.
- **Request issue:**
  - When no request is locked, the lowest-index PEND entry is selected.
  - Once `req_valid` is high with retry, the selected entry is locked until transfer. Newly allocated lower-index entries do not displace it.
  - On transfer the entry moves PEND→WAIT. `req_tid` equals the entry index.
- **Ack:**
  - An entry in WAIT whose index equals `ack_tid` stores ppn and fault and moves WAIT→FILL.
  - An ack to a non-WAIT entry is dropped and sets `err`. `err` is cleared only by reset.
- **Fill:**
  - Uses the same lowest-index selection and lock rule as requests, over FILL entries.
  - On transfer the entry moves FILL→FREE.
- An entry freed in cycle N is allocatable from cycle N+1, not in cycle N.
- `busy` = OR of (state≠FREE).

## Timing
- **Reset:** all entries FREE, locks cleared. `req_valid=0`, `fill_valid=0`, `busy=0`, `err=0`, `miss_retry=1`, `ack_retry=0`. Reset mid-transaction discards all entries; acks arriving later set `err`.
- **Miss to request:** a miss accepted at edge N gives `req_valid=1` in cycle N+1, when no other request is pending or locked.
- **Ack to fill:** an ack at edge M gives `fill_valid=1` in cycle M+1.
- **Output timing:** `req_*`, `fill_*` and `busy` are driven from registered state only. `miss_retry` is combinational from state and `miss_vpn`.
- **Concurrency:** miss, request transfer, ack and fill transfer can all occur in one cycle on different entries, and all take effect.
- **Full queue:** when all entries are non-FREE, a miss to a new VPN is retried, while a duplicate VPN is accepted.

## Test plan
- Reset, then miss vpn=0x12345 -> request vpn=0x12345, tid=0 next cycle. Ack tid=0, ppn=0xABCDE -> fill of 0x12345→0xABCDE one cycle later. Afterwards `busy=0`.
- Miss 0x100 with prefetch=1, then miss 0x100 with prefetch=0 while WAIT -> exactly one request is issued, and the fill has prefetch=0.
- Four distinct misses with Entries=4 -> fifth distinct VPN is retried and a duplicate of the third is accepted. After one fill transfer, the fifth is accepted in the following cycle, not the same cycle.
- Hold `req_retry=1` for 5 cycles with tid=2 valid while entry 0 is newly allocated -> tid and vpn stay 2 until transfer, then tid 0 is issued.
- Acks out of order (tid 1 then 0), with `fill_retry=1` for 3 cycles -> fill payload is held stable, fills occur in lowest-index order, and faults propagate.
- Ack tid=3 while entry 3 is FREE -> `err=1` and stays 1 until reset; no fill occurs.
